// File: rtl/lsu_pkg.sv
// Shared load/store definitions: RV32 funct3 width codes, response fault causes
// and the handshake FSM state type.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_RANGE    = 2'b10;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Stores only have B/H/W; unsigned variants are load-only.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      if (we) return f3[2] || (f3 == 3'b011);
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for word-organised memories: store byte mask and replicated
// write data, load lane extraction with sign/zero extension, and misalignment.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
   assign half_sel = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

   // Write data is replicated across lanes so the byte mask alone picks the target.
   always_comb begin
      be_o       = 4'b0000;
      wdata_o    = 32'h0;
      rdata_o    = 32'h0;
      misalign_o = 1'b0;
      case (funct3_i)
         F3_B, F3_BU: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = funct3_i[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         F3_H, F3_HU: begin
            be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o    = {2{wdata_i[15:0]}};
            rdata_o    = funct3_i[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            misalign_o = addr_lo_i[0];
         end
         F3_W: begin
            be_o       = 4'b1111;
            wdata_o    = wdata_i;
            rdata_o    = rword_i;
            misalign_o = |addr_lo_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/data_mem_hs.sv
// Handshaked data memory: one outstanding load/store, response after READ_LAT
// cycles, faults reported in the response instead of being dropped.
module data_mem_hs
   import lsu_pkg::*;
#(
   parameter int unsigned DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned READ_LAT  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  rsp_cause,
   output logic [1:0]  dbg_state
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0] mem_q [DEPTH];
   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;
   logic [1:0]  rsp_cause_q;

   logic          accept;
   logic [29:0]   word_idx;
   logic [AW-1:0] idx;
   logic          out_of_range;
   logic          misalign;
   logic [1:0]    cause;
   logic [3:0]    be;
   logic [31:0]   wdata_lanes;
   logic [31:0]   ld_data;

   assign word_idx     = 30'((req_addr - BASE_ADDR) >> 2);
   assign idx          = word_idx[AW-1:0];
   assign out_of_range = (req_addr < BASE_ADDR) || ({2'b00, word_idx} >= DEPTH);

   lsu_align u_align (
      .funct3_i  (req_funct3),
      .addr_lo_i (req_addr[1:0]),
      .wdata_i   (req_wdata),
      .rword_i   (mem_q[idx]),
      .be_o      (be),
      .wdata_o   (wdata_lanes),
      .rdata_o   (ld_data),
      .misalign_o(misalign)
   );

   always_comb begin
      cause = CAUSE_NONE;
      if (f3_illegal(req_we, req_funct3)) cause = CAUSE_ILLEGAL;
      else if (misalign)                  cause = CAUSE_MISALIGN;
      else if (out_of_range)              cause = CAUSE_RANGE;
   end

   assign accept = req_valid && req_ready;

   // Storage is not reset; a store commits on its accept edge.
   always_ff @(posedge clk) begin
      if (accept && req_we && (cause == CAUSE_NONE)) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 2'd0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
         rsp_cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            rsp_err_q   <= (cause != CAUSE_NONE);
            rsp_cause_q <= cause;
            rsp_rdata_q <= (req_we || (cause != CAUSE_NONE)) ? 32'h0 : ld_data;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (READ_LAT > 1) begin
                  state_d = WAIT;
                  cnt_d   = 2'(READ_LAT - 1);
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 2'd1) state_d = RESP;
            else               cnt_d   = cnt_q - 2'd1;
         end
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = rst_n && (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      rsp_rdata = rsp_rdata_q;
      rsp_err   = rsp_err_q;
      rsp_cause = rsp_cause_q;
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs: instance 0 uses READ_LAT=1, instance 1 READ_LAT=3.
module tb_data_mem_hs;
   import lsu_pkg::*;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic [1:0]  exp_c;
   } vec_t;

   logic        clk;
   logic        rst_n      [2];
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_we     [2];
   logic [2:0]  req_funct3 [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic        rsp_valid  [2];
   logic        rsp_ready  [2];
   logic [31:0] rsp_rdata  [2];
   logic        rsp_err    [2];
   logic [1:0]  rsp_cause  [2];
   logic [1:0]  dbg_state  [2];

   int n_cmp  = 0;
   int n_fail = 0;

   data_mem_hs #(.DEPTH(64), .BASE_ADDR(32'h0), .READ_LAT(1)) dut0 (
      .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .rsp_cause(rsp_cause[0]),
      .dbg_state(dbg_state[0])
   );

   data_mem_hs #(.DEPTH(64), .BASE_ADDR(32'h0), .READ_LAT(3)) dut1 (
      .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .rsp_cause(rsp_cause[1]),
      .dbg_state(dbg_state[1])
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // Driver: one full transaction with rsp_ready high; returns response and latency.
   task automatic xact(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e, output logic [1:0] c,
                       output int lat);
      int g;
      @(negedge clk);
      req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
      req_addr[d] = a; req_wdata[d] = wd; rsp_ready[d] = 1'b1;
      g = 0;
      while (req_ready[d] !== 1'b1 && g < 20) begin
         @(negedge clk);
         g++;
      end
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0; req_we[d] = ~we; req_funct3[d] = 3'b111;
      req_addr[d] = 32'hFFFF_FFFF; req_wdata[d] = 32'h0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (rsp_valid[d] !== 1'b1 && lat < 20);
      rd = rsp_rdata[d]; e = rsp_err[d]; c = rsp_cause[d];
      @(posedge clk);
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; req_valid[d] = 1'b0; rsp_ready[d] = 1'b0;
         req_we[d] = 1'b0; req_funct3[d] = 3'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if ({rsp_valid[d], rsp_err[d], rsp_cause[d], rsp_rdata[d], req_ready[d], dbg_state[d]}
             !== {1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 2'(IDLE)}) begin
            n_fail++;
            $display("FAIL reset_state[%0d] got v=%b e=%b c=%b rd=%h rdy=%b st=%0d want all 0, IDLE",
                     d, rsp_valid[d], rsp_err[d], rsp_cause[d], rsp_rdata[d], req_ready[d], dbg_state[d]);
         end
         rst_n[d] = 1'b1;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (req_ready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready[%0d] got %b want 1", d, req_ready[d]);
         end
      end
   endtask

   task automatic test_word();
      vec_t v[2];
      logic [31:0] rd; logic e; logic [1:0] c; int lat;
      v = '{'{1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 32'h0, CAUSE_NONE},
            '{1'b0, F3_W, 32'h10, 32'h0, 32'hDEAD_BEEF, CAUSE_NONE}};
      foreach (v[i]) begin
         xact(0, v[i].we, v[i].f3, v[i].a, v[i].wd, rd, e, c, lat);
         n_cmp++;
         if (rd !== v[i].exp_rd || e !== (v[i].exp_c != 2'b00) || c !== v[i].exp_c || lat !== 1) begin
            n_fail++;
            $display("FAIL word[%0d] got rd=%h err=%b cause=%b lat=%0d want rd=%h cause=%b lat=1",
                     i, rd, e, c, lat, v[i].exp_rd, v[i].exp_c);
         end
      end
   endtask

   task automatic test_subword();
      vec_t v[4];
      logic [31:0] rd; logic e; logic [1:0] c; int lat;
      v = '{'{1'b0, F3_B,  32'h13, 32'h0, 32'hFFFF_FFDE, CAUSE_NONE},
            '{1'b0, F3_BU, 32'h13, 32'h0, 32'h0000_00DE, CAUSE_NONE},
            '{1'b0, F3_H,  32'h12, 32'h0, 32'hFFFF_DEAD, CAUSE_NONE},
            '{1'b0, F3_HU, 32'h10, 32'h0, 32'h0000_BEEF, CAUSE_NONE}};
      foreach (v[i]) begin
         xact(0, v[i].we, v[i].f3, v[i].a, v[i].wd, rd, e, c, lat);
         n_cmp++;
         if (rd !== v[i].exp_rd || e !== 1'b0 || c !== v[i].exp_c || lat !== 1) begin
            n_fail++;
            $display("FAIL subword[%0d] got rd=%h err=%b cause=%b lat=%0d want rd=%h cause=%b lat=1",
                     i, rd, e, c, lat, v[i].exp_rd, v[i].exp_c);
         end
      end
   endtask

   task automatic test_partial_store();
      vec_t v[4];
      logic [31:0] rd; logic e; logic [1:0] c; int lat;
      v = '{'{1'b1, F3_B, 32'h11, 32'hAABB_CC55, 32'h0, CAUSE_NONE},
            '{1'b0, F3_W, 32'h10, 32'h0, 32'hDEAD_55EF, CAUSE_NONE},
            '{1'b1, F3_H, 32'h12, 32'hFFFF_1234, 32'h0, CAUSE_NONE},
            '{1'b0, F3_W, 32'h10, 32'h0, 32'h1234_55EF, CAUSE_NONE}};
      foreach (v[i]) begin
         xact(0, v[i].we, v[i].f3, v[i].a, v[i].wd, rd, e, c, lat);
         n_cmp++;
         if (rd !== v[i].exp_rd || e !== 1'b0 || c !== v[i].exp_c || lat !== 1) begin
            n_fail++;
            $display("FAIL partial_store[%0d] got rd=%h err=%b cause=%b lat=%0d want rd=%h cause=%b lat=1",
                     i, rd, e, c, lat, v[i].exp_rd, v[i].exp_c);
         end
      end
   endtask

   task automatic test_errors();
      vec_t v[14];
      logic [31:0] rd; logic e; logic [1:0] c; int lat;
      v = '{'{1'b0, F3_W,   32'h02,  32'h0,         32'h0,         CAUSE_MISALIGN},
            '{1'b1, F3_W,   32'h00,  32'hCAFE_F00D, 32'h0,         CAUSE_NONE},
            '{1'b1, F3_W,   32'h100, 32'h0,         32'h0,         CAUSE_RANGE},
            '{1'b0, F3_W,   32'h00,  32'h0,         32'hCAFE_F00D, CAUSE_NONE},
            '{1'b0, F3_H,   32'h101, 32'h0,         32'h0,         CAUSE_MISALIGN},
            '{1'b0, 3'b111, 32'h10,  32'h0,         32'h0,         CAUSE_ILLEGAL},
            '{1'b0, 3'b011, 32'h01,  32'h0,         32'h0,         CAUSE_ILLEGAL},
            '{1'b1, 3'b100, 32'h10,  32'h0,         32'h0,         CAUSE_ILLEGAL},
            '{1'b1, F3_H,   32'h13,  32'h0,         32'h0,         CAUSE_MISALIGN},
            '{1'b0, F3_W,   32'h10,  32'h0,         32'h1234_55EF, CAUSE_NONE},
            '{1'b1, F3_W,   32'hFC,  32'h0BAD_F00D, 32'h0,         CAUSE_NONE},
            '{1'b0, F3_W,   32'hFC,  32'h0,         32'h0BAD_F00D, CAUSE_NONE},
            '{1'b0, F3_B,   32'hFF,  32'h0,         32'h0000_000B, CAUSE_NONE},
            '{1'b0, F3_BU,  32'h100, 32'h0,         32'h0,         CAUSE_RANGE}};
      foreach (v[i]) begin
         xact(0, v[i].we, v[i].f3, v[i].a, v[i].wd, rd, e, c, lat);
         n_cmp++;
         if (rd !== v[i].exp_rd || e !== (v[i].exp_c != 2'b00) || c !== v[i].exp_c || lat !== 1) begin
            n_fail++;
            $display("FAIL errors[%0d] got rd=%h err=%b cause=%b lat=%0d want rd=%h cause=%b lat=1",
                     i, rd, e, c, lat, v[i].exp_rd, v[i].exp_c);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic e; logic [1:0] c; int lat;
      for (int k = 0; k < 2; k++) begin
         xact(0, 1'b0, F3_HU, 32'h12, 32'h0, rd, e, c, lat);
         n_cmp++;
         if (rd !== 32'h0000_1234 || lat !== 1) begin
            n_fail++;
            $display("FAIL b2b_data[%0d] got rd=%h lat=%0d want 00001234 lat=1", k, rd, lat);
         end
         #1;
         n_cmp++;
         if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || dbg_state[0] !== 2'(IDLE)) begin
            n_fail++;
            $display("FAIL b2b_ready[%0d] got rdy=%b v=%b st=%0d want 1 0 IDLE",
                     k, req_ready[0], rsp_valid[0], dbg_state[0]);
         end
      end
   endtask

   task automatic test_latency();
      logic [31:0] rd; logic e; logic [1:0] c; int lat;
      xact(1, 1'b1, F3_W, 32'h20, 32'hA5A5_5A5A, rd, e, c, lat);
      n_cmp++;
      if (rd !== 32'h0 || e !== 1'b0 || lat !== 3) begin
         n_fail++;
         $display("FAIL lat3_store got rd=%h err=%b lat=%0d want 0 0 3", rd, e, lat);
      end
      @(negedge clk);
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = F3_HU;
      req_addr[1] = 32'h22; req_wdata[1] = 32'h0; rsp_ready[1] = 1'b0;
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0; req_addr[1] = 32'h0;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         n_cmp++;
         if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL lat3_wait[%0d] got v=%b rdy=%b want 0 0", k, rsp_valid[1], req_ready[1]);
         end
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_cmp++;
         if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'h0000_A5A5 || rsp_err[1] !== 1'b0 ||
             req_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL lat3_hold[%0d] got v=%b rd=%h err=%b rdy=%b want 1 0000a5a5 0 0",
                     k, rsp_valid[1], rsp_rdata[1], rsp_err[1], req_ready[1]);
         end
      end
      rsp_ready[1] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[1] = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL lat3_release got v=%b rdy=%b want 0 1", rsp_valid[1], req_ready[1]);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic e; logic [1:0] c; int lat;
      @(negedge clk);
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = F3_W;
      req_addr[1] = 32'h24; req_wdata[1] = 32'h600D_CAFE; rsp_ready[1] = 1'b1;
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (dbg_state[1] !== 2'(WAIT)) begin
         n_fail++;
         $display("FAIL rst_mid_wait got st=%0d want %0d", dbg_state[1], 2'(WAIT));
      end
      rst_n[1] = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (rsp_valid[1] !== 1'b0 || dbg_state[1] !== 2'(IDLE) || req_ready[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_abandon got v=%b st=%0d rdy=%b want 0 IDLE 0",
                  rsp_valid[1], dbg_state[1], req_ready[1]);
      end
      rst_n[1] = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_release got rdy=%b v=%b want 1 0", req_ready[1], rsp_valid[1]);
      end
      xact(1, 1'b0, F3_W, 32'h24, 32'h0, rd, e, c, lat);
      n_cmp++;
      if (rd !== 32'h600D_CAFE || e !== 1'b0 || lat !== 3) begin
         n_fail++;
         $display("FAIL rst_mid_commit got rd=%h err=%b lat=%0d want 600dcafe 0 3", rd, e, lat);
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_subword();
      test_partial_store();
      test_errors();
      test_back_to_back();
      test_latency();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
